// File: rtl/cdc_result_tally_if.sv
// cdc_result_tally_if: clk3-domain frame inputs and decoded results of the card-game tally block
interface cdc_result_tally_if #(
    parameter int PROB_W = 7,
    parameter int CNT_W  = 8
);
    logic              out_valid1;
    logic              equal;
    logic              exceed;
    logic              out_valid2;
    logic              winner;
    logic              tally_clr;
    logic              prob_valid;
    logic [PROB_W-1:0] prob_equal;
    logic [PROB_W-1:0] prob_exceed;
    logic              range_err;
    logic              round_done;
    logic [CNT_W-1:0]  wins1;
    logic [CNT_W-1:0]  wins2;
    logic [CNT_W-1:0]  draws;
    logic              proto_err;

    modport master (
        output out_valid1, equal, exceed, out_valid2, winner, tally_clr,
        input  prob_valid, prob_equal, prob_exceed, range_err, round_done,
               wins1, wins2, draws, proto_err
    );

    modport slave (
        input  out_valid1, equal, exceed, out_valid2, winner, tally_clr,
        output prob_valid, prob_equal, prob_exceed, range_err, round_done,
               wins1, wins2, draws, proto_err
    );
endinterface

// File: rtl/cdc_result_tally.sv
// cdc_result_tally: deserializes probability words, decodes winner frames, keeps saturating tallies
module cdc_result_tally #(
    parameter int PROB_W = 7,
    parameter int CNT_W  = 8
) (
    input logic               clk3,
    input logic               rst_n,
    cdc_result_tally_if.slave bus
);
    localparam int CW = $clog2(PROB_W + 1);
    localparam logic [PROB_W-1:0] P_MAX = PROB_W'(100);

    typedef enum logic {P_IDLE, P_SHIFT} p_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEL, W_DRAIN} w_state_t;

    p_state_t          p_state, p_next;
    w_state_t          w_state, w_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [PROB_W-1:0] sh_eq, sh_ex, eq_next, ex_next;
    logic              commit, p_err;
    logic              seen, seen_next;
    logic              inc_d, inc1, inc2, w_err;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && c != '1) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        p_next   = p_state;
        cnt_next = cnt;
        eq_next  = sh_eq;
        ex_next  = sh_ex;
        commit   = 1'b0;
        p_err    = 1'b0;
        if (bus.out_valid1) begin
            eq_next  = p_state == P_IDLE ? PROB_W'(bus.equal) : {sh_eq[PROB_W-2:0], bus.equal};
            ex_next  = p_state == P_IDLE ? PROB_W'(bus.exceed) : {sh_ex[PROB_W-2:0], bus.exceed};
            cnt_next = p_state == P_IDLE ? CW'(1) : cnt + CW'(1);
            commit   = cnt_next == CW'(PROB_W);
            p_next   = commit ? P_IDLE : P_SHIFT;
        end else if (p_state == P_SHIFT) begin
            p_err    = 1'b1;
            p_next   = P_IDLE;
            cnt_next = '0;
        end
    end

    // seen marks that the current excess frame in W_DRAIN has already been reported
    always_comb begin
        w_next    = w_state;
        seen_next = seen;
        inc_d     = 1'b0;
        inc1      = 1'b0;
        inc2      = 1'b0;
        w_err     = 1'b0;
        if (w_state == W_IDLE) begin
            if (bus.out_valid2) begin
                inc_d     = !bus.winner;
                w_next    = bus.winner ? W_SEL : W_DRAIN;
                seen_next = 1'b0;
            end
        end else if (w_state == W_SEL) begin
            inc1      = bus.out_valid2 && !bus.winner;
            inc2      = bus.out_valid2 && bus.winner;
            w_err     = !bus.out_valid2;
            w_next    = bus.out_valid2 ? W_DRAIN : W_IDLE;
            seen_next = 1'b0;
        end else begin
            w_err     = bus.out_valid2 && !seen;
            seen_next = bus.out_valid2;
            w_next    = bus.out_valid2 ? W_DRAIN : W_IDLE;
        end
    end

    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            p_state         <= P_IDLE;
            w_state         <= W_IDLE;
            cnt             <= '0;
            sh_eq           <= '0;
            sh_ex           <= '0;
            seen            <= 1'b0;
            bus.prob_valid  <= 1'b0;
            bus.prob_equal  <= '0;
            bus.prob_exceed <= '0;
            bus.range_err   <= 1'b0;
            bus.round_done  <= 1'b0;
            bus.wins1       <= '0;
            bus.wins2       <= '0;
            bus.draws       <= '0;
            bus.proto_err   <= 1'b0;
        end else begin
            p_state        <= p_next;
            w_state        <= w_next;
            cnt            <= cnt_next;
            sh_eq          <= eq_next;
            sh_ex          <= ex_next;
            seen           <= seen_next;
            bus.prob_valid <= commit;
            bus.range_err  <= commit && (eq_next > P_MAX || ex_next > P_MAX);
            if (commit) begin
                bus.prob_equal  <= eq_next;
                bus.prob_exceed <= ex_next;
            end
            bus.round_done <= inc_d | inc1 | inc2;
            bus.wins1      <= bus.tally_clr ? '0 : bump(bus.wins1, inc1);
            bus.wins2      <= bus.tally_clr ? '0 : bump(bus.wins2, inc2);
            bus.draws      <= bus.tally_clr ? '0 : bump(bus.draws, inc_d);
            bus.proto_err  <= p_err | w_err;
        end
    end
endmodule

// File: tb/tb_cdc_result_tally.sv
// tb_cdc_result_tally: directed vectors with hand-computed expectations for cdc_result_tally
module tb_cdc_result_tally;
    logic clk3 = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cdc_result_tally_if #(.PROB_W(7), .CNT_W(8)) bus ();

    cdc_result_tally #(.PROB_W(7), .CNT_W(8)) dut (
        .clk3 (clk3),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk3 = ~clk3;

    task automatic step();
        @(posedge clk3);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_prob(input logic [6:0] e, input logic [6:0] x);
        for (int i = 6; i >= 0; i--) begin
            bus.out_valid1 = 1'b1;
            bus.equal      = e[i];
            bus.exceed     = x[i];
            step();
        end
    endtask

    task automatic win2(input logic b);
        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b1;
        step();
        bus.winner = b;
        step();
        bus.out_valid2 = 1'b0;
        step();
    endtask

    initial begin
        bus.out_valid1 = 1'b0;
        bus.equal      = 1'b0;
        bus.exceed     = 1'b0;
        bus.out_valid2 = 1'b0;
        bus.winner     = 1'b0;
        bus.tally_clr  = 1'b0;
        step();
        step();
        chk("rst_prob_valid", bus.prob_valid, 0);
        chk("rst_prob_equal", bus.prob_equal, 0);
        chk("rst_wins1", bus.wins1, 0);
        chk("rst_wins2", bus.wins2, 0);
        chk("rst_draws", bus.draws, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        rst_n = 1'b1;
        step();

        send_prob(7'b0110010, 7'b0011001);
        chk("p1_valid", bus.prob_valid, 1);
        chk("p1_equal", bus.prob_equal, 50);
        chk("p1_exceed", bus.prob_exceed, 25);
        chk("p1_range", bus.range_err, 0);
        bus.out_valid1 = 1'b0;
        step();
        chk("p1_valid_pulse", bus.prob_valid, 0);
        chk("p1_equal_hold", bus.prob_equal, 50);

        send_prob(7'b1100100, 7'b1100100);
        chk("b2b1_valid", bus.prob_valid, 1);
        chk("b2b1_equal", bus.prob_equal, 100);
        chk("b2b1_range", bus.range_err, 0);
        send_prob(7'b1111111, 7'b1111111);
        chk("b2b2_valid", bus.prob_valid, 1);
        chk("b2b2_equal", bus.prob_equal, 127);
        chk("b2b2_exceed", bus.prob_exceed, 127);
        chk("b2b2_range", bus.range_err, 1);
        chk("b2b2_proto", bus.proto_err, 0);
        bus.out_valid1 = 1'b0;
        step();
        chk("b2b_range_pulse", bus.range_err, 0);

        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b0;
        step();
        chk("draw_done", bus.round_done, 1);
        chk("draw_cnt", bus.draws, 1);
        bus.out_valid2 = 1'b0;
        step();
        chk("draw_done_pulse", bus.round_done, 0);
        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b1;
        step();
        chk("sel_no_done", bus.round_done, 0);
        bus.winner = 1'b0;
        step();
        chk("w1_done", bus.round_done, 1);
        chk("w1_cnt", bus.wins1, 1);
        bus.out_valid2 = 1'b0;
        step();
        win2(1'b1);
        win2(1'b1);
        chk("w2_cnt", bus.wins2, 2);
        chk("w1_keep", bus.wins1, 1);
        chk("draw_keep", bus.draws, 1);

        bus.equal  = 1'b1;
        bus.exceed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.out_valid1 = 1'b1;
            step();
        end
        bus.out_valid1 = 1'b0;
        step();
        chk("p_trunc_err", bus.proto_err, 1);
        chk("p_trunc_valid", bus.prob_valid, 0);
        chk("p_trunc_equal", bus.prob_equal, 127);
        step();
        chk("p_trunc_err_pulse", bus.proto_err, 0);
        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b1;
        step();
        bus.out_valid2 = 1'b0;
        step();
        chk("w_trunc_err", bus.proto_err, 1);
        chk("w_trunc_done", bus.round_done, 0);
        chk("w_trunc_wins2", bus.wins2, 2);
        step();
        chk("w_trunc_err_pulse", bus.proto_err, 0);

        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b1;
        step();
        step();
        step();
        chk("excess_err", bus.proto_err, 1);
        step();
        chk("excess_err_once", bus.proto_err, 0);
        bus.out_valid2 = 1'b0;
        step();
        chk("excess_wins2", bus.wins2, 3);

        for (int i = 0; i < 300; i++) win2(1'b1);
        chk("sat_wins2", bus.wins2, 255);
        bus.out_valid2 = 1'b1;
        bus.winner     = 1'b1;
        step();
        bus.tally_clr = 1'b1;
        step();
        chk("clr_wins2", bus.wins2, 0);
        chk("clr_wins1", bus.wins1, 0);
        chk("clr_draws", bus.draws, 0);
        bus.tally_clr  = 1'b0;
        bus.out_valid2 = 1'b0;
        step();

        bus.equal  = 1'b1;
        bus.exceed = 1'b0;
        bus.out_valid1 = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.out_valid1 = 1'b0;
        step();
        chk("mid_rst_err", bus.proto_err, 0);
        chk("mid_rst_equal", bus.prob_equal, 0);
        send_prob(7'b0000001, 7'b0000000);
        chk("post_rst_valid", bus.prob_valid, 1);
        chk("post_rst_equal", bus.prob_equal, 1);
        chk("post_rst_err", bus.proto_err, 0);
        bus.out_valid1 = 1'b0;
        step();
        chk("post_rst_err2", bus.proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cdc_result_tally.md
# cdc_result_tally

Downstream consumer of the card-game CDC block's clk3-domain outputs. Deserializes the 7-bit serial probability words carried on `equal`/`exceed` while `out_valid1` is high. Decodes the 1- or 2-cycle `winner` frame carried while `out_valid2` is high. Keeps saturating tallies of user1 wins, user2 wins and no-winner rounds, and flags any frame that violates the upstream protocol.

## Interface
Parameters:
- `PROB_W`, 7, width of each serial probability word (percent, 0..100)
- `CNT_W`, 8, width of each tally counter

Ports:
- `clk3`  in  1  clock; one clock domain, same as upstream output domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `out_valid1`  in  1  probability frame valid (upstream output)
- `equal`  in  1  serial bit of P(equal), MSB first
- `exceed`  in  1  serial bit of P(exceed), MSB first
- `out_valid2`  in  1  winner frame valid (upstream output)
- `winner`  in  1  serial winner bit
- `tally_clr`  in  1  synchronous clear of all counters
- `prob_valid`  out  1  one-cycle pulse: `prob_equal`/`prob_exceed` updated
- `prob_equal`  out  PROB_W  last complete P(equal) word
- `prob_exceed`  out  PROB_W  last complete P(exceed) word
- `range_err`  out  1  pulse with `prob_valid` when either word > 100
- `round_done`  out  1  one-cycle pulse: a winner frame was decoded
- `wins1`, `wins2`, `draws`  out  CNT_W each  tallies
- `proto_err`  out  1  one-cycle pulse on a malformed frame

## Operation
Probability path (FSM P_IDLE, P_SHIFT):
- P_IDLE: `out_valid1`=1 loads bit 0 into both shift registers, sets bit count to 1, and moves to P_SHIFT.
- P_SHIFT: each cycle with `out_valid1`=1 shifts left and increments the count.
- When the count reaches PROB_W, the words are committed to `prob_equal`/`prob_exceed` and the FSM returns to P_IDLE.
- `out_valid1` dropping with count < PROB_W: frame discarded, `proto_err` pulses, outputs unchanged, return to P_IDLE.
- `out_valid1` still high after the PROB_W-th bit: that cycle starts a new frame (back-to-back frames allowed).
- `range_err`: word value > 100. The word is still committed.

Winner path (FSM W_IDLE, W_SEL, W_DRAIN):
- W_IDLE, `out_valid2`=1, `winner`=0: no-winner round; `draws`+1. Next state is W_DRAIN if `out_valid2` is still high next cycle, else W_IDLE.
- W_IDLE, `out_valid2`=1, `winner`=1: go to W_SEL.
- W_SEL, `out_valid2`=1: `winner`=0 gives `wins1`+1, 1 gives `wins2`+1; go to W_DRAIN.
- W_SEL, `out_valid2`=0: truncated frame; `proto_err`, no count, go to W_IDLE.
- W_DRAIN: waits for `out_valid2`=0. Any high cycle here pulses `proto_err` once per excess frame and is ignored.

Arithmetic and control:
- Counters saturate at 2^CNT_W−1 and never wrap.
- `tally_clr` zeroes all three counters. If it coincides with an increment, the clear wins (result 0).
- `tally_clr` does not affect the FSMs or the probability registers.
- The two paths are independent; simultaneous frames on both are legal.
- `proto_err` is the OR of both paths' error pulses.

## Timing
- Reset values: all outputs 0, both FSMs idle, shift registers and counts 0.
- Asynchronous reset mid-frame abandons the frame; the first frame after release is treated as new.
- Inputs are sampled on the rising edge of `clk3`.
- `prob_valid`/`range_err` are registered and assert the cycle after the PROB_W-th bit is sampled. The words are stable from that cycle until the next commit.
- `round_done` and the counter update occur on the edge after the deciding bit. With `winner`=0 in W_IDLE, `round_done` is high the cycle after that sample; 2-bit frames likewise.
- `proto_err` asserts the cycle after the offending sample.
- No input backpressure; the block must accept one bit per cycle continuously.

## Test plan
- `out_valid1` high 7 cycles, `equal` bits 0110010 and `exceed` bits 0011001 (MSB first) -> `prob_valid` pulses one cycle later; `prob_equal`=50, `prob_exceed`=25, `range_err`=0.
- 14 consecutive cycles carrying 1100100 then 1111111 -> two `prob_valid` pulses 7 cycles apart; values 100 then 127; `range_err` only on the second.
- Winner frames {0}, {1,0}, {1,1}, {1,1} separated by idle cycles -> `draws`=1, `wins1`=1, `wins2`=2; four `round_done` pulses.
- `out_valid1` high 4 cycles then low; `out_valid2` frame {1} then low -> two `proto_err` pulses, outputs and counters unchanged.
- 300 {1,1} frames -> `wins2` saturates at 255. `tally_clr` on the same cycle as one further increment -> `wins2`=0.
- `rst_n` asserted during the 3rd probability bit, then a full 7-bit frame of 0000001 -> `prob_equal`=1; no `proto_err` after reset.
